// File: rtl/muldiv_seq_pkg.sv
// Shared RV32M encodings, MDU state encoding and the controller-side decode qualifier.
package muldiv_seq_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_DONE = 2'b10
  } mdu_state_e;

  // Controller uses this to swap the ALU result for the MDU result on done.
  function automatic logic rv32_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage to multiply/divide unit handshake bundle.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, srca, srcb, flush,
    input  stall, done, result
  );

  modport slave (
    input  start, funct3, srca, srcb, flush,
    output stall, done, result
  );
endinterface

// File: rtl/muldiv_iter.sv
// One radix-2 step: shift-add multiply on {hi,lo} or restoring shift-subtract divide on {rem,quo}.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              step_en,
  input  logic              is_div,
  input  logic [XLEN-1:0]   opnd,
  input  logic [2*XLEN-1:0] acc_in,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    hi       = acc_in[2*XLEN-1:XLEN];
    lo       = acc_in[XLEN-1:0];
    // Multiplier bits are consumed from lo[0]; the carry out of the add shifts into hi.
    sum      = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    mul_next = {sum, lo[XLEN-1:1]};
    // Remainder stays below the divisor, so one extra bit holds the shifted value and the borrow.
    rem_sh   = {hi, lo[XLEN-1]};
    diff     = rem_sh - {1'b0, opnd};
    div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0],   lo[XLEN-2:0], 1'b1};
    acc_out  = acc_in;
    if (step_en) begin
      acc_out = is_div ? div_next : mul_next;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit for the EX stage: stalls the front end while iterating,
// returns the result with a one-cycle done pulse.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_seq_if.slave bus
);

  localparam int              CNT_W    = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   opnd_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic [CNT_W-1:0]  count_q;

  logic              accept;
  logic              is_div_in;
  logic              a_signed, b_signed;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  always_comb begin
    is_div_in = bus.funct3[2];
    a_signed  = (bus.funct3 == FUNCT3_MULH) || (bus.funct3 == FUNCT3_MULHSU) ||
                (is_div_in && !bus.funct3[0]);
    b_signed  = (bus.funct3 == FUNCT3_MULH) || (is_div_in && !bus.funct3[0]);
    a_neg     = a_signed && bus.srca[XLEN-1];
    b_neg     = b_signed && bus.srcb[XLEN-1];
    a_mag     = cond_neg(bus.srca, a_neg);
    b_mag     = cond_neg(bus.srcb, b_neg);
    div_zero  = is_div_in && (bus.srcb == '0);
    div_ovf   = is_div_in && !bus.funct3[0] && (bus.srca == INT_MIN) && (bus.srcb == '1);
    accept    = (state_q == MDU_IDLE) && bus.start && !bus.flush;
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .step_en (state_q == MDU_CALC),
    .is_div  (op_q[2]),
    .opnd    (opnd_q),
    .acc_in  (acc_q),
    .acc_out (acc_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MDU_IDLE;
      op_q      <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= bus.funct3;
        count_q <= '0;
        // Fast paths preload the final {rem,quo} so DONE needs no special casing.
        if (div_zero) begin
          acc_q     <= {bus.srca, {XLEN{1'b1}}};
          opnd_q    <= '0;
          neg_res_q <= 1'b0;
          neg_rem_q <= 1'b0;
        end else if (div_ovf) begin
          acc_q     <= {{XLEN{1'b0}}, INT_MIN};
          opnd_q    <= '0;
          neg_res_q <= 1'b0;
          neg_rem_q <= 1'b0;
        end else begin
          acc_q     <= {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
          opnd_q    <= is_div_in ? b_mag : a_mag;
          neg_res_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
        end
      end else if (state_q == MDU_CALC) begin
        acc_q   <= acc_step;
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bus.stall = 1'b0;
    bus.done  = 1'b0;
    unique case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          bus.stall = 1'b1;
          state_d   = (div_zero || div_ovf) ? MDU_DONE : MDU_CALC;
        end
      end
      MDU_CALC: begin
        bus.stall = 1'b1;
        if (count_q == LAST_CNT) state_d = MDU_DONE;
      end
      MDU_DONE: begin
        bus.done = 1'b1;
        state_d  = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
    if (bus.flush) state_d = MDU_IDLE;
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   sel;

  always_comb begin
    prod = cond_neg_wide(acc_q, neg_res_q);
    quo  = cond_neg(acc_q[XLEN-1:0], neg_res_q);
    rem  = cond_neg(acc_q[2*XLEN-1:XLEN], neg_rem_q);
    unique case (op_q)
      FUNCT3_MUL:                            sel = prod[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: sel = prod[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:               sel = quo;
      default:                               sel = rem;
    endcase
    bus.result = (state_q == MDU_DONE) ? sel : '0;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: result values, done latency, stall window, flush and reset.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  muldiv_seq_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32), .ITERS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [6:0]  lat;
  } vec_t;

  vec_t tbl [0:13] = '{
    '{FUNCT3_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 7'd33},
    '{FUNCT3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 7'd33},
    '{FUNCT3_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 7'd33},
    '{FUNCT3_MULHSU, 32'hFFFFFFFF,   32'h00000002, 32'hFFFFFFFF, 7'd33},
    '{FUNCT3_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 7'd33},
    '{FUNCT3_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 7'd33},
    '{FUNCT3_DIVU,   32'd100,        32'd7,        32'd14,       7'd33},
    '{FUNCT3_REMU,   32'd100,        32'd7,        32'd2,        7'd33},
    '{FUNCT3_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 7'd1},
    '{FUNCT3_REM,    32'd5,          32'd0,        32'd5,        7'd1},
    '{FUNCT3_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 7'd1},
    '{FUNCT3_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000, 7'd1},
    '{FUNCT3_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 7'd1},
    '{FUNCT3_DIVU,   32'h80000000,   32'hFFFFFFFF, 32'h00000000, 7'd33}
  };

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0]        up;
    logic signed [31:0] q;
    logic               ovf;
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    ub  = $signed({32'd0, b});
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (f)
      FUNCT3_MUL:    return a * b;
      FUNCT3_MULH:   begin p = sa * sb; return p[63:32]; end
      FUNCT3_MULHSU: begin p = sa * ub; return p[63:32]; end
      FUNCT3_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      FUNCT3_DIV:    begin
        if (b == 0) return 32'hFFFFFFFF;
        if (ovf) return 32'h80000000;
        q = $signed(a) / $signed(b);
        return q;
      end
      FUNCT3_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
      FUNCT3_REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default:       return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      default: return $urandom();
    endcase
  endfunction

  // Called at a falling edge: presents an op and records what it must produce.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat);
    exp_t e;
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.srca   = a;
    bus.srcb   = b;
    e.res = res;
    e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Follows one op from its start cycle; operands are scrambled once start drops.
  task automatic run_to_done(output int lat, output logic [31:0] res, output int stall_hi,
                             output logic stall_at_done);
    lat = -1; res = '0; stall_hi = 0; stall_at_done = 1'b0;
    #1;
    if (bus.stall) stall_hi++;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start  = 1'b0;
        bus.funct3 = ~bus.funct3;
        bus.srca   = $urandom();
        bus.srcb   = $urandom();
      end
      #1;
      if (bus.done) begin
        lat = c; res = bus.result; stall_at_done = bus.stall;
        break;
      end
      if (bus.stall) stall_hi++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.srca = '0; bus.srcb = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h want=0", bus.result); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_arith();
    int lat, sh; logic [31:0] res; logic sd; exp_t e;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      issue(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].res, int'(tbl[i].lat));
      run_to_done(lat, res, sh, sd);
      e = sb_q.pop_front();
      checks++; if (res !== e.res) begin errors++; $display("FAIL arith[%0d]_result got=%h want=%h", i, res, e.res); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL arith[%0d]_latency got=%0d want=%0d", i, lat, e.lat); end
      checks++; if (sh !== e.lat) begin errors++; $display("FAIL arith[%0d]_stall_cycles got=%0d want=%0d", i, sh, e.lat); end
      checks++; if (sd !== 1'b0) begin errors++; $display("FAIL arith[%0d]_stall_in_done got=%b want=0", i, sd); end
      @(negedge clk); #1;
      checks++;
      if ({bus.done, bus.result} !== 33'd0) begin
        errors++; $display("FAIL arith[%0d]_after_done done=%b result=%h want 0/0", i, bus.done, bus.result);
      end
    end
  endtask

  task automatic test_random();
    int lat, sh; logic [31:0] res, a, b; logic [2:0] f; logic sd, fast; exp_t e;
    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      fast = f[2] && ((b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
      @(negedge clk);
      issue(f, a, b, ref_model(f, a, b), fast ? 1 : 33);
      run_to_done(lat, res, sh, sd);
      e = sb_q.pop_front();
      checks++;
      if (res !== e.res || lat !== e.lat) begin
        errors++;
        $display("FAIL random[%0d] f=%0d a=%h b=%h got=%h@%0d want=%h@%0d", i, f, a, b, res, lat, e.res, e.lat);
      end
    end
  endtask

  task automatic test_flush();
    int lat, sh; logic [31:0] res; logic sd, seen; exp_t e;
    seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = FUNCT3_DIV; bus.srca = 32'd1000; bus.srcb = 32'd3;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1)  bus.start = 1'b0;
      if (c == 10) bus.flush = 1'b1;
      if (c == 11) bus.flush = 1'b0;
      #1;
      if (bus.done) seen = 1'b1;
      if (c == 10) begin
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL flush_stall_calc got=%b want=1", bus.stall); end
      end
      if (c == 11) begin
        checks++;
        if ({bus.stall, bus.done, bus.result} !== 34'd0) begin
          errors++; $display("FAIL flush_idle stall=%b done=%b result=%h want 0/0/0", bus.stall, bus.done, bus.result);
        end
      end
    end
    @(negedge clk);
    issue(FUNCT3_MUL, 32'd3, 32'd4, 32'd12, 33);
    run_to_done(lat, res, sh, sd);
    e = sb_q.pop_front();
    checks++; if (res !== e.res) begin errors++; $display("FAIL flush_next_result got=%h want=%h", res, e.res); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL flush_next_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_done got=%b want=0", seen); end
  endtask

  task automatic test_reset_mid_op();
    int n_done;
    n_done = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = FUNCT3_MUL; bus.srca = 32'd5; bus.srcb = 32'd6;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 5) reset = 1'b1;
      if (c == 6) reset = 1'b0;
      #1;
      if (c == 6) begin
        checks++;
        if ({bus.stall, bus.done, bus.result} !== 34'd0) begin
          errors++; $display("FAIL reset_mid stall=%b done=%b result=%h want 0/0/0", bus.stall, bus.done, bus.result);
        end
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (bus.done) n_done++;
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL reset_mid_no_done got=%0d want=0", n_done); end
  endtask

  task automatic test_back_to_back();
    int n_done; exp_t e;
    n_done = 0;
    @(negedge clk);
    issue(FUNCT3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (c == 33) issue(FUNCT3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 67);
      if (c == 35) bus.start = 1'b0;
      #1;
      if (bus.done) begin
        n_done++;
        if (sb_q.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_extra_done at cycle %0d result=%h", c, bus.result);
        end else begin
          e = sb_q.pop_front();
          checks++; if (bus.result !== e.res) begin errors++; $display("FAIL b2b_result got=%h want=%h", bus.result, e.res); end
          checks++; if (c !== e.lat) begin errors++; $display("FAIL b2b_latency got=%0d want=%0d", c, e.lat); end
        end
      end
    end
    checks++; if (n_done !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d want=2", n_done); end
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_random();
    test_flush();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
